uart_rx_engine: RTL and testbench

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

---
 rtl/uart_rx_engine.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// Serial receiver: 2-flop synchronised rx, mid-bit sampling, 7/8 data bits, optional odd/even parity.
// rx_data and flags update on the stop-bit sample cycle. There is no backpressure: an unread character is overwritten and ovf is set.
module uart_rx_engine #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] baud,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] rx_data,
    output logic       rxrdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    // Sized for the slowest rate, which has the longest bit time.
    localparam int CW = $clog2(CLK_FREQ / 300 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    function automatic logic [CW-1:0] bit_time(input logic [3:0] sel);
        case (sel)
            4'd0:    bit_time = CW'(CLK_FREQ / 300);
            4'd1:    bit_time = CW'(CLK_FREQ / 1200);
            4'd2:    bit_time = CW'(CLK_FREQ / 2400);
            4'd3:    bit_time = CW'(CLK_FREQ / 4800);
            4'd4:    bit_time = CW'(CLK_FREQ / 9600);
            4'd5:    bit_time = CW'(CLK_FREQ / 19200);
            4'd6:    bit_time = CW'(CLK_FREQ / 38400);
            4'd7:    bit_time = CW'(CLK_FREQ / 57600);
            4'd8:    bit_time = CW'(CLK_FREQ / 115200);
            4'd9:    bit_time = CW'(CLK_FREQ / 230400);
            4'd10:   bit_time = CW'(CLK_FREQ / 460800);
            default: bit_time = CW'(CLK_FREQ / 921600);
        endcase
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par_bit, par_nxt;
    logic          rx_s1, rx_s2, rx_prev;
    logic [3:0]    baud_l;
    logic          eight_l, pen_l, ohel_l;
    logic          cfg_load, frame_done;
    logic          rx_fall, expire;
    logic [CW-1:0] bt_m1;
    logic [7:0]    data_word;
    logic          par_exp;

    assign rx_fall   = rx_prev & ~rx_s2;
    assign expire    = (cnt == '0);
    assign bt_m1     = bit_time(baud_l) - CW'(1);
    // In 7-bit mode the character sits one place high in the shifter.
    assign data_word = eight_l ? shreg : {1'b0, shreg[7:1]};
    assign par_exp   = ohel_l ? ~^data_word : ^data_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bitcnt  <= bitcnt_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = expire ? '0 : cnt - CW'(1);
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        par_nxt    = par_bit;
        cfg_load   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt = START;
                    cnt_nxt   = (bit_time(baud) >> 1) - CW'(1);
                    cfg_load  = 1'b1;
                end
            end
            START: begin
                if (expire) begin
                    if (rx_s2) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt  = DATA;
                        cnt_nxt    = bt_m1;
                        bitcnt_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_nxt = {rx_s2, shreg[7:1]};
                    cnt_nxt   = bt_m1;
                    if (bitcnt == (eight_l ? 3'd7 : 3'd6)) begin
                        state_nxt = pen_l ? PAR : STOP;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end
            end
            PAR: begin
                if (expire) begin
                    par_nxt   = rx_s2;
                    cnt_nxt   = bt_m1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_l  <= '0;
            eight_l <= 1'b0;
            pen_l   <= 1'b0;
            ohel_l  <= 1'b0;
        end else if (cfg_load) begin
            baud_l  <= baud;
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
        end
    end

    // Completion has priority over a coincident read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data <= '0;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (frame_done) begin
            rx_data <= data_word;
            rxrdy   <= 1'b1;
            ferr    <= ~rx_s2;
            perr    <= pen_l & (par_bit != par_exp);
            ovf     <= rxrdy & ~read;
        end else if (read) begin
            rxrdy   <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: directed frames, with a monitor that checks every completed character.
`timescale 1ns/1ps
module tb_uart_rx_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] baud;
    logic       eight, pen, ohel, rx, read;
    logic [7:0] rx_data;
    logic       rxrdy, perr, ferr, ovf;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   bit_ns = 17361;
    int   lat;
    int   lat_dummy;

    uart_rx_engine #(.CLK_FREQ(100_000_000)) dut (
        .clock   (clock),
        .reset   (reset),
        .baud    (baud),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .rx      (rx),
        .read    (read),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic p, input logic f, input logic o);
        sb.push_back(exp_t'({d, p, f, o}));
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input bit par, input bit stop);
        @(negedge clock);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        if (has_par) begin
            rx = par;
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
        rx = 1'b1;
        #(bit_ns);
    endtask

    // 8-bit parity frame; lat = negedges from the start edge until d is presented.
    // A non-zero read_at raises read across the edge before negedge read_at.
    task automatic send_timed(input logic [7:0] d, input bit par, input int read_at, output int lat_o);
        int n;
        n = 0;
        fork
            send_frame(d, 8, 1'b1, par, 1'b1);
            begin
                @(negedge clock);
                while (!(rxrdy && rx_data == d) && n < 30000) begin
                    @(negedge clock);
                    n++;
                end
            end
            begin
                @(negedge clock);
                if (read_at > 0) begin
                    repeat (read_at - 1) @(negedge clock);
                    read = 1'b1;
                    @(negedge clock);
                    read = 1'b0;
                end
            end
        join
        lat_o = n;
    endtask

    task automatic pulse_read();
        @(negedge clock);
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        @(negedge clock);
    endtask

    initial begin : monitor
        logic [11:0] prev, cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clock);
            cur = {rx_data, perr, ferr, ovf, rxrdy};
            if (reset) begin
                prev = '0;
            end else begin
                if (rxrdy && cur != prev) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame: got data 0x%0h perr %0b ferr %0b ovf %0b, required no completion",
                                 rx_data, perr, ferr, ovf);
                    end else begin
                        e = sb.pop_front();
                        if ({rx_data, perr, ferr, ovf} !== e) begin
                            errors++;
                            $display("FAIL frame: got data 0x%0h perr %0b ferr %0b ovf %0b, required data 0x%0h perr %0b ferr %0b ovf %0b",
                                     rx_data, perr, ferr, ovf, e.data, e.perr, e.ferr, e.ovf);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        read  = 1'b0;
        baud  = 4'd7;
        eight = 1'b1;
        pen   = 1'b1;
        ohel  = 1'b1;
        #1;
        check("reset_outputs", 32'({rx_data, rxrdy, perr, ferr, ovf}), 32'd0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Clean frame at 57600 with odd parity, plus start-to-ready latency.
        expect_frame(8'h6A, 1'b0, 1'b0, 1'b0);
        send_timed(8'h6A, 1'b1, 0, lat);
        checks++;
        if (lat < 18224 || lat > 18232) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 18224..18232", lat);
        end
        pulse_read();
        check("read_clears_rxrdy", 32'(rxrdy), 32'd0);

        // Remaining traffic at 921600 to keep the run short.
        baud   = 4'd11;
        bit_ns = 1085;

        expect_frame(8'h6F, 1'b1, 1'b0, 1'b0);
        send_frame(8'h6F, 8, 1'b1, 1'b0, 1'b1);
        pulse_read();
        check("perr_persists_after_read", 32'(perr), 32'd1);

        eight = 1'b0;
        pen   = 1'b0;
        expect_frame(8'h2A, 1'b0, 1'b1, 1'b0);
        send_frame(8'h2A, 7, 1'b0, 1'b0, 1'b0);
        pulse_read();
        check("ferr_persists_after_read", 32'({ferr, rxrdy}), 32'h2);

        // Changing baud mid-frame must not disturb the frame in flight.
        expect_frame(8'h40, 1'b0, 1'b0, 1'b0);
        fork
            send_frame(8'h40, 7, 1'b0, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge clock);
                baud = 4'd0;
            end
        join
        baud = 4'd11;
        pulse_read();

        eight = 1'b1;
        pen   = 1'b1;
        expect_frame(8'h73, 1'b0, 1'b0, 1'b0);
        send_frame(8'h73, 8, 1'b1, 1'b0, 1'b1);
        expect_frame(8'h65, 1'b0, 1'b0, 1'b1);
        send_frame(8'h65, 8, 1'b1, 1'b1, 1'b1);
        check("overrun_data", 32'(rx_data), 32'h65);
        pulse_read();
        check("read_clears_rxrdy_ovf", 32'({rxrdy, ovf}), 32'd0);

        // Read landing on the completion edge: completion wins, no overrun.
        expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_timed(8'h11, 1'b1, 0, lat);
        expect_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_timed(8'h22, 1'b1, lat, lat_dummy);
        check("coincident_rxrdy_ovf", 32'({rxrdy, ovf}), 32'h2);
        pulse_read();

        // 400 ns glitch on an idle line.
        @(negedge clock);
        rx = 1'b0;
        #400;
        rx = 1'b1;
        #(3 * bit_ns);
        check("glitch_no_rxrdy", 32'(rxrdy), 32'd0);

        expect_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of the data bits.
        @(negedge clock);
        rx = 1'b0;
        #(bit_ns);
        rx = 1'b1;
        #(bit_ns);
        rx = 1'b0;
        #(bit_ns / 2);
        reset = 1'b1;
        #50;
        rx = 1'b1;
        #50;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_mid_frame_outputs", 32'({rx_data, rxrdy, perr, ferr, ovf}), 32'd0);

        expect_frame(8'h08, 1'b0, 1'b0, 1'b0);
        send_frame(8'h08, 8, 1'b1, 1'b0, 1'b1);

        repeat (20) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
